rst_release_seq: RTL and testbench

Reset release sequencer for the multi-clock system. It drives the asynchronous, active-low reset inputs of the per-domain reset synchronizers and releases them one domain at a time, in index order. Before releasing the next domain it waits for that domain's "reset released" acknowledge, then a fixed gap. It also performs a reverse-order software-requested re-reset and reports a timeout fault if a domain never acknowledges.

---
 rtl/rst_release_seq_if.sv | 30 +++
 rtl/rst_release_seq.sv | 144 ++++++++++++++
 tb/tb_rst_release_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rst_release_seq_if.sv
// Handshake bundle between the reset release sequencer and the per-domain
// reset synchronizers / software control.
interface rst_release_seq_if #(
    parameter int NUM_DOMAINS = 3
);
    logic                   i_SW_RST_REQ;
    logic [NUM_DOMAINS-1:0] i_DOM_RDY;
    logic [NUM_DOMAINS-1:0] o_DOM_RST_N;
    logic                   o_SEQ_DONE;
    logic                   o_TIMEOUT;
    logic                   o_BUSY;

    modport master (
        output i_SW_RST_REQ,
        output i_DOM_RDY,
        input  o_DOM_RST_N,
        input  o_SEQ_DONE,
        input  o_TIMEOUT,
        input  o_BUSY
    );

    modport slave (
        input  i_SW_RST_REQ,
        input  i_DOM_RDY,
        output o_DOM_RST_N,
        output o_SEQ_DONE,
        output o_TIMEOUT,
        output o_BUSY
    );
endinterface

// File: rtl/rst_release_seq.sv
// Releases per-domain resets one at a time in index order, waiting for each
// domain's ack plus a fixed gap; supports reverse-order re-reset and ack timeout.
module rst_release_seq #(
    parameter int NUM_DOMAINS    = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    rst_release_seq_if.slave   bus
);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_ACK,
        S_GAP,
        S_DONE,
        S_ASSERT,
        S_FAULT
    } state_t;

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [NUM_DOMAINS-1:0] dom_rst_n_reg;
    logic                   seq_done_reg;
    logic                   timeout_reg;
    logic                   busy_reg;

    // One-hot view of idx so bit updates need no variable part-selects.
    logic [NUM_DOMAINS-1:0] idx_hot;
    logic [NUM_DOMAINS-1:0] next_hot;
    logic                   rdy_sel;
    logic                   idx_last;

    generate
        for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_hot
            assign idx_hot[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign next_hot = idx_hot << 1;
    assign rdy_sel  = |(bus.i_DOM_RDY & idx_hot);
    assign idx_last = (idx_reg == IDX_W'(NUM_DOMAINS - 1));

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_reg     <= S_HOLD;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            dom_rst_n_reg <= '0;
            seq_done_reg  <= 1'b0;
            timeout_reg   <= 1'b0;
            busy_reg      <= 1'b1;
        end else begin
            case (state_reg)
                S_HOLD: begin
                    if (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) begin
                        dom_rst_n_reg <= dom_rst_n_reg | idx_hot;
                        cnt_reg       <= '0;
                        state_reg     <= S_WAIT_ACK;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                S_WAIT_ACK: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (rdy_sel) begin
                        if (idx_last) begin
                            seq_done_reg <= 1'b1;
                            busy_reg     <= 1'b0;
                            state_reg    <= S_DONE;
                        end else begin
                            cnt_reg   <= '0;
                            state_reg <= S_GAP;
                        end
                    end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_reg   <= 1'b1;
                        dom_rst_n_reg <= '0;
                        busy_reg      <= 1'b0;
                        seq_done_reg  <= 1'b0;
                        state_reg     <= S_FAULT;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                S_GAP: begin
                    if (cnt_reg == CNT_W'(GAP_CYCLES - 1)) begin
                        idx_reg       <= idx_reg + 1'b1;
                        dom_rst_n_reg <= dom_rst_n_reg | next_hot;
                        cnt_reg       <= '0;
                        state_reg     <= S_WAIT_ACK;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                S_DONE: begin
                    if (bus.i_SW_RST_REQ) begin
                        seq_done_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        idx_reg      <= IDX_W'(NUM_DOMAINS - 1);
                        state_reg    <= S_ASSERT;
                    end
                end

                S_ASSERT: begin
                    // Walk back down, re-asserting one domain per cycle.
                    dom_rst_n_reg <= dom_rst_n_reg & ~idx_hot;
                    if (idx_reg == '0) begin
                        cnt_reg   <= '0;
                        state_reg <= S_HOLD;
                    end else begin
                        idx_reg <= idx_reg - 1'b1;
                    end
                end

                S_FAULT: begin
                    if (bus.i_SW_RST_REQ) begin
                        timeout_reg <= 1'b0;
                        busy_reg    <= 1'b1;
                        cnt_reg     <= '0;
                        idx_reg     <= '0;
                        state_reg   <= S_HOLD;
                    end
                end

                default: begin
                    state_reg <= S_HOLD;
                end
            endcase
        end
    end

    assign bus.o_DOM_RST_N = dom_rst_n_reg;
    assign bus.o_SEQ_DONE  = seq_done_reg;
    assign bus.o_TIMEOUT   = timeout_reg;
    assign bus.o_BUSY      = busy_reg;
endmodule

// File: tb/tb_rst_release_seq.sv
// Directed bench for rst_release_seq: expected output snapshots are queued per
// edge number and compared 1 time unit after that edge.
module tb_rst_release_seq;
    localparam int N = 3;
    localparam int H = 16;
    localparam int G = 4;
    localparam int T = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rst_release_seq_if #(.NUM_DOMAINS(N)) bus ();

    logic [N-1:0] rdy_mask  = '1;
    logic [N-1:0] rdy_force = '0;
    assign bus.i_DOM_RDY = (bus.o_DOM_RST_N & rdy_mask) | rdy_force;

    rst_release_seq #(
        .NUM_DOMAINS(N), .HOLD_CYCLES(H), .GAP_CYCLES(G),
        .TIMEOUT_CYCLES(T), .CNT_W(9)
    ) dut (
        .i_CLK(clk),
        .i_RST(rst),
        .bus(bus)
    );

    int tests  = 0;
    int failed = 0;
    int edge_no = 0;

    // Scoreboard: edge number, tag, expected {rst_n[2:0], done, timeout, busy}.
    int        q_edge[$];
    string     q_tag[$];
    logic [5:0] q_val[$];

    task automatic expect_at(input int e, input string tag, input logic [N-1:0] rn,
                             input logic done, input logic tout, input logic busy);
        q_edge.push_back(e);
        q_tag.push_back(tag);
        q_val.push_back({rn, done, tout, busy});
    endtask

    task automatic check_due();
        int e;
        string tag;
        logic [5:0] exp_v;
        logic [5:0] obs_v;
        while (q_edge.size() > 0 && q_edge[0] <= edge_no) begin
            e     = q_edge.pop_front();
            tag   = q_tag.pop_front();
            exp_v = q_val.pop_front();
            obs_v = {bus.o_DOM_RST_N, bus.o_SEQ_DONE, bus.o_TIMEOUT, bus.o_BUSY};
            tests++;
            assert (obs_v === exp_v && e == edge_no)
                $display("[TB] edge %0d %s rst_n/done/tout/busy=%b ok", edge_no, tag, obs_v);
            else begin
                failed++;
                $error("FAIL %s at edge %0d (queued for %0d): observed=%b expected=%b",
                       tag, edge_no, e, obs_v, exp_v);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_no++;
        #1;
        check_due();
    endtask

    task automatic run_to(input int e);
        check_due();
        while (edge_no < e) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_SW_RST_REQ = 1'b0;
        rdy_force = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        edge_no = 0;
    endtask

    task automatic sw_pulse_at(input int e);
        run_to(e - 1);
        bus.i_SW_RST_REQ = 1'b1;
        step();
        bus.i_SW_RST_REQ = 1'b0;
    endtask

    task automatic push_normal(input string s);
        expect_at(0,  {s, "_reset"},  3'b000, 1'b0, 1'b0, 1'b1);
        expect_at(15, {s, "_hold15"}, 3'b000, 1'b0, 1'b0, 1'b1);
        expect_at(16, {s, "_rel0"},   3'b001, 1'b0, 1'b0, 1'b1);
        expect_at(20, {s, "_gap0"},   3'b001, 1'b0, 1'b0, 1'b1);
        expect_at(21, {s, "_rel1"},   3'b011, 1'b0, 1'b0, 1'b1);
        expect_at(25, {s, "_gap1"},   3'b011, 1'b0, 1'b0, 1'b1);
        expect_at(26, {s, "_rel2"},   3'b111, 1'b0, 1'b0, 1'b1);
        expect_at(27, {s, "_done"},   3'b111, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        bus.i_SW_RST_REQ = 1'b0;

        // Normal release with acks tied to the resets, then software re-reset.
        rdy_mask = '1;
        do_reset();
        push_normal("s1");
        expect_at(30, "s3_req",    3'b111, 1'b0, 1'b0, 1'b1);
        expect_at(31, "s3_assert2", 3'b011, 1'b0, 1'b0, 1'b1);
        expect_at(32, "s3_assert1", 3'b001, 1'b0, 1'b0, 1'b1);
        expect_at(33, "s3_assert0", 3'b000, 1'b0, 1'b0, 1'b1);
        expect_at(48, "s3_hold",   3'b000, 1'b0, 1'b0, 1'b1);
        expect_at(49, "s3_rel0",   3'b001, 1'b0, 1'b0, 1'b1);
        expect_at(60, "s3_done",   3'b111, 1'b1, 1'b0, 1'b0);
        sw_pulse_at(30);
        run_to(60);

        // Software requests during HOLD, WAIT_ACK and GAP are ignored.
        do_reset();
        push_normal("s6");
        sw_pulse_at(5);
        sw_pulse_at(17);
        sw_pulse_at(19);
        run_to(27);

        // Domain 1 never acks: timeout, then software recovery.
        rdy_mask = 3'b101;
        do_reset();
        expect_at(21,  "s2_rel1",    3'b011, 1'b0, 1'b0, 1'b1);
        expect_at(276, "s2_preto",   3'b011, 1'b0, 1'b0, 1'b1);
        expect_at(277, "s2_timeout", 3'b000, 1'b0, 1'b1, 1'b0);
        expect_at(299, "s2_sticky",  3'b000, 1'b0, 1'b1, 1'b0);
        expect_at(300, "s2_recover", 3'b000, 1'b0, 1'b0, 1'b1);
        expect_at(315, "s2_hold",    3'b000, 1'b0, 1'b0, 1'b1);
        expect_at(316, "s2_rel0",    3'b001, 1'b0, 1'b0, 1'b1);
        sw_pulse_at(300);
        run_to(316);

        // Ack arriving on the very timeout edge wins.
        rdy_mask = 3'b101;
        do_reset();
        expect_at(277, "s5_noto",  3'b011, 1'b0, 1'b0, 1'b1);
        expect_at(280, "s5_gap",   3'b011, 1'b0, 1'b0, 1'b1);
        expect_at(281, "s5_rel2",  3'b111, 1'b0, 1'b0, 1'b1);
        expect_at(282, "s5_done",  3'b111, 1'b1, 1'b0, 1'b0);
        run_to(276);
        rdy_force = 3'b010;
        run_to(282);
        rdy_force = '0;

        // Reset pulse in the middle of GAP.
        rdy_mask = '1;
        do_reset();
        expect_at(18, "s4_gap",   3'b001, 1'b0, 1'b0, 1'b1);
        expect_at(19, "s4_rst",   3'b000, 1'b0, 1'b0, 1'b1);
        run_to(18);
        rst = 1'b1;
        step();
        rst = 1'b0;
        edge_no = 0;
        expect_at(15, "s4_hold",  3'b000, 1'b0, 1'b0, 1'b1);
        expect_at(16, "s4_rel0",  3'b001, 1'b0, 1'b0, 1'b1);
        run_to(16);

        if (q_edge.size() != 0) begin
            failed++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", q_edge.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
